// File: rtl/conv_result_fifo.sv
// conv_result_fifo: buffers one convolution result per store command and drains them over valid/ready on read.
//   clk            : system clock, rising edge
//   reset          : asynchronous active-high reset
//   fifo_command   : 00 idle, 10 write, 01 read/drain, 11 clear (edge-qualified against previous cycle)
//   data_in        : result word, captured on a write edge
//   data_out       : show-ahead head word (0 when empty)
//   data_out_valid : head word valid while draining
//   data_out_ready : consumer accepts the head word
//   full / empty   : registered occupancy flags
//   level          : entry count 0..DEPTH
//   overflow       : sticky, a write was dropped while full
//   drain_done     : one-cycle pulse when a drain completes
module conv_result_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            fifo_command,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   input  logic                  data_out_ready,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  drain_done
);
   typedef enum logic [1:0] {FILL = 2'b00, DRAIN = 2'b01} state_t;
   state_t state, state_next;
   logic [1:0] cmd_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0] level_next;
   logic wr_ev, rd_ev, clr_ev, pop, do_write, done_next;
   // a held command only acts on the cycle it first appears
   assign wr_ev  = fifo_command == 2'b10 && cmd_q != 2'b10;
   assign rd_ev  = fifo_command == 2'b01 && cmd_q != 2'b01;
   assign clr_ev = fifo_command == 2'b11 && cmd_q != 2'b11;
   assign data_out_valid = state == DRAIN && !empty;
   assign data_out = empty ? '0 : mem[rd_ptr];
   assign pop = data_out_valid && data_out_ready && !clr_ev;
   // a simultaneous pop frees a slot, so a write while full still lands
   assign do_write = wr_ev && (!full || pop);
   assign level_next = level + (ADDR_WIDTH+1)'(do_write) - (ADDR_WIDTH+1)'(pop);
   always_comb begin
      state_next = state;
      done_next = 1'b0;
      case (state)
         FILL:    state_next = rd_ev ? DRAIN : FILL;
         DRAIN:   begin
            state_next = (level_next == '0) ? FILL : DRAIN;
            done_next = level_next == '0;
         end
         default: state_next = FILL;
      endcase
      if (clr_ev) begin
         state_next = FILL;
         done_next = 1'b0;
      end
   end
   always_ff @(posedge clk)
      if (do_write) mem[wr_ptr] <= data_in;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= FILL;
         cmd_q <= 2'b00;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         empty <= 1'b1;
         full <= 1'b0;
         overflow <= 1'b0;
         drain_done <= 1'b0;
      end else begin
         state <= state_next;
         cmd_q <= fifo_command;
         drain_done <= done_next;
         if (clr_ev) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            empty <= 1'b1;
            full <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (do_write) wr_ptr <= (wr_ptr == ADDR_WIDTH'(DEPTH-1)) ? '0 : wr_ptr + ADDR_WIDTH'(1);
            if (pop) rd_ptr <= (rd_ptr == ADDR_WIDTH'(DEPTH-1)) ? '0 : rd_ptr + ADDR_WIDTH'(1);
            if (wr_ev && !do_write) overflow <= 1'b1;
            level <= level_next;
            empty <= level_next == '0;
            full <= level_next == (ADDR_WIDTH+1)'(DEPTH);
         end
      end
endmodule

// File: tb/tb_conv_result_fifo.sv
// tb_conv_result_fifo: scoreboard bench for conv_result_fifo.
module tb_conv_result_fifo;
   localparam int DW = 32;
   localparam int DEPTH = 256;
   logic clk = 0;
   logic reset = 1;
   logic [1:0] fifo_command = 2'b00;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic data_out_valid;
   logic data_out_ready = 0;
   logic full, empty, overflow, drain_done;
   logic [8:0] level;
   int vectors = 0;
   int errors = 0;
   logic [DW-1:0] q[$];

   conv_result_fifo dut (
      .clk(clk), .reset(reset), .fifo_command(fifo_command), .data_in(data_in),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .full(full), .empty(empty), .level(level), .overflow(overflow), .drain_done(drain_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      fifo_command = 2'b10;
      data_in = d;
      if (q.size() < DEPTH) q.push_back(d);
      cyc();
      fifo_command = 2'b00;
      cyc();
   endtask

   task automatic drain(input logic [3:0] pat);
      int n = 0;
      int pulses = 0;
      int budget = 0;
      logic [DW-1:0] held = '0;
      logic [DW-1:0] exp;
      bit stalled = 0;
      fifo_command = 2'b01;
      cyc();
      fifo_command = 2'b00;
      while (q.size() > 0 && budget < 2000) begin
         if (drain_done) pulses++;
         vectors++;
         if (level !== 9'(q.size())) begin
            errors++;
            $display("FAIL drain_level: got %0d expected %0d", level, q.size());
         end
         if (stalled) begin
            vectors++;
            if (data_out !== held) begin
               errors++;
               $display("FAIL stall_hold: got %h expected %h", data_out, held);
            end
         end
         data_out_ready = pat[n % 4];
         n++;
         if (data_out_valid && data_out_ready) begin
            exp = q.pop_front();
            vectors++;
            if (data_out !== exp) begin
               errors++;
               $display("FAIL drain_data: got %h expected %h", data_out, exp);
            end
            stalled = 0;
         end else begin
            stalled = data_out_valid;
            held = data_out;
         end
         cyc();
         budget++;
      end
      data_out_ready = 0;
      vectors++;
      if (budget >= 2000) begin
         errors++;
         $display("FAIL drain_timeout: %0d words left expected 0", q.size());
      end
      vectors++;
      if (drain_done !== 1'b1) begin
         errors++;
         $display("FAIL drain_done_timing: got %b expected 1", drain_done);
      end
      for (int i = 0; i < 4; i++) begin
         if (drain_done) pulses++;
         cyc();
      end
      vectors++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL drain_done_count: got %0d expected 1", pulses);
      end
      vectors++;
      if ({data_out_valid, empty, level} !== {1'b0, 1'b1, 9'd0}) begin
         errors++;
         $display("FAIL post_drain: got valid=%b empty=%b level=%0d expected 0 1 0", data_out_valid, empty, level);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      cyc();
      cyc();
      vectors++;
      if ({level, empty, full, overflow, drain_done, data_out_valid} !== {9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_flags: got level=%0d e=%b f=%b o=%b dd=%b v=%b expected 0 1 0 0 0 0", level, empty, full, overflow, drain_done, data_out_valid);
      end
      vectors++;
      if (data_out !== '0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", data_out);
      end
      reset = 0;
      cyc();
   endtask

   task automatic test_basic();
      write_word(32'h11);
      write_word(32'h22);
      write_word(32'h33);
      vectors++;
      if (level !== 9'd3 || data_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_fill: got level=%0d valid=%b expected 3 0", level, data_out_valid);
      end
      drain(4'b1111);
   endtask

   task automatic test_hold();
      fifo_command = 2'b10;
      data_in = 32'hAA;
      q.push_back(32'hAA);
      for (int i = 0; i < 5; i++) cyc();
      fifo_command = 2'b00;
      cyc();
      vectors++;
      if (level !== 9'd1) begin
         errors++;
         $display("FAIL held_write_level: got %0d expected 1", level);
      end
      drain(4'b1111);
   endtask

   task automatic test_full_overflow();
      for (int i = 0; i < DEPTH; i++) write_word(DW'(i));
      vectors++;
      if (full !== 1'b1 || level !== 9'd256 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_flags: got f=%b level=%0d o=%b expected 1 256 0", full, level, overflow);
      end
      write_word(32'hDEAD);
      vectors++;
      if (full !== 1'b1 || level !== 9'd256 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flags: got f=%b level=%0d o=%b expected 1 256 1", full, level, overflow);
      end
      drain(4'b1111);
      vectors++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: got %b expected 1", overflow);
      end
   endtask

   task automatic test_clear();
      write_word(32'h5);
      write_word(32'h6);
      fifo_command = 2'b11;
      cyc();
      fifo_command = 2'b00;
      q.delete();
      vectors++;
      if ({overflow, level, empty, full, drain_done} !== {1'b0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL clear: got o=%b level=%0d e=%b f=%b dd=%b expected 0 0 1 0 0", overflow, level, empty, full, drain_done);
      end
      cyc();
   endtask

   task automatic test_stall();
      for (int i = 0; i < 5; i++) write_word(32'hC0DE_0000 + DW'(i));
      drain(4'b1001);
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      write_word(32'hB1);
      fifo_command = 2'b01;
      cyc();
      vectors++;
      if (data_out_valid !== 1'b1 || data_out !== 32'hB1) begin
         errors++;
         $display("FAIL b2b_head: got valid=%b data=%h expected 1 b1", data_out_valid, data_out);
      end
      fifo_command = 2'b10;
      data_in = 32'hB2;
      data_out_ready = 1;
      void'(q.pop_front());
      q.push_back(32'hB2);
      cyc();
      if (drain_done) pulses++;
      fifo_command = 2'b00;
      data_out_ready = 0;
      vectors++;
      if (level !== 9'd1 || empty !== 1'b0 || data_out_valid !== 1'b1 || data_out !== 32'hB2) begin
         errors++;
         $display("FAIL b2b_overlap: got level=%0d e=%b v=%b data=%h expected 1 0 1 b2", level, empty, data_out_valid, data_out);
      end
      data_out_ready = 1;
      cyc();
      data_out_ready = 0;
      void'(q.pop_front());
      vectors++;
      if (drain_done !== 1'b1 || level !== 9'd0 || pulses != 0) begin
         errors++;
         $display("FAIL b2b_done: got dd=%b level=%0d early=%0d expected 1 0 0", drain_done, level, pulses);
      end
      cyc();
   endtask

   task automatic test_empty_read();
      int pulses = 0;
      int valids = 0;
      fifo_command = 2'b01;
      cyc();
      fifo_command = 2'b00;
      for (int i = 0; i < 6; i++) begin
         if (drain_done) pulses++;
         if (data_out_valid) valids++;
         cyc();
      end
      vectors++;
      if (pulses != 1 || valids != 0) begin
         errors++;
         $display("FAIL empty_read: got pulses=%0d valids=%0d expected 1 0", pulses, valids);
      end
      write_word(32'h77);
      vectors++;
      if (data_out_valid !== 1'b0 || level !== 9'd1) begin
         errors++;
         $display("FAIL empty_read_fill: got valid=%b level=%0d expected 0 1", data_out_valid, level);
      end
   endtask

   task automatic test_async_reset();
      write_word(32'h91);
      write_word(32'h92);
      fifo_command = 2'b01;
      cyc();
      fifo_command = 2'b00;
      vectors++;
      if (data_out_valid !== 1'b1 || data_out !== 32'h77) begin
         errors++;
         $display("FAIL pre_reset_drain: got valid=%b data=%h expected 1 77", data_out_valid, data_out);
      end
      #2;
      reset = 1;
      #1;
      q.delete();
      vectors++;
      if ({data_out_valid, level, empty, full, overflow, drain_done} !== {1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0} || data_out !== '0) begin
         errors++;
         $display("FAIL async_reset: got v=%b level=%0d e=%b f=%b o=%b dd=%b data=%h expected 0 0 1 0 0 0 0", data_out_valid, level, empty, full, overflow, drain_done, data_out);
      end
      cyc();
      reset = 0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_full_overflow();
      test_clear();
      test_stall();
      test_back_to_back();
      test_empty_read();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/conv_result_fifo.md
Name: conv_result_fifo

Overview:
Downstream stage of the convolution controller. It buffers one convolved output value per MEM_STORE pass, as commanded by the controller's fifo_command bus. When the controller issues the READ command at end of frame, the block drains the stored results to the external consumer over a valid/ready handshake. It sits between the datapath's final adder level (L4_ADD output) and the host/readout interface.

Parameters:
DATA_WIDTH, 32, width of one convolution result word
DEPTH, 256, number of result entries (one per MEM_STORE pass per frame)
ADDR_WIDTH, 8, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
fifo_command  input  2  from controller: 2'b00 idle, 2'b10 write, 2'b01 read/drain, 2'b11 clear
data_in  input  DATA_WIDTH  result word from L4_ADD stage, stable while fifo_command==2'b10
data_out  output  DATA_WIDTH  word at head of FIFO
data_out_valid  output  1  head word valid for consumer
data_out_ready  input  1  consumer accepts head word
full  output  1  DEPTH entries stored
empty  output  1  no entries stored
level  output  ADDR_WIDTH+1  current entry count, 0..DEPTH
overflow  output  1  sticky: a write was dropped because FIFO was full
drain_done  output  1  one-cycle pulse, drain completed

Behaviour:
- Reset (async, active-high) forces: state=FILL, wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, overflow=0, drain_done=0, data_out_valid=0, data_out=0, cmd_q=2'b00.
- cmd_q is a register holding the previous cycle's fifo_command. Commands are edge-qualified: an event fires only when fifo_command==X and cmd_q!=X. A command held for many cycles acts once.
- Write event (edge to 2'b10):
  - Not full: data_in is written to mem[wr_ptr] at that clock edge; wr_ptr+1 wraps modulo DEPTH; level+1.
  - Full: word is dropped, overflow<=1, pointers unchanged.
  - Writes are accepted in both FILL and DRAIN states.
- Read event (edge to 2'b01): state FILL->DRAIN. Ignored if already in DRAIN.
- DRAIN handshake:
  - data_out_valid = (state==DRAIN) && !empty. data_out = mem[rd_ptr] (show-ahead; combinational from array, 0 when empty).
  - Pop occurs when data_out_valid && data_out_ready at the clock edge: rd_ptr+1 wraps; level-1.
  - data_out must remain stable while valid && !ready.
- Drain completion:
  - A pop that makes level 0 causes drain_done=1 for exactly the next cycle, and state->FILL.
  - Entering DRAIN while already empty pulses drain_done the following cycle and returns to FILL.
- Same-cycle write and pop: both occur; level unchanged; full/empty unchanged unless boundary crossed by pointer math. A write while full with a simultaneous pop is accepted (full evaluated after pop).
- Clear event (edge to 2'b11): pointers=0, level=0, overflow=0, state=FILL, no drain_done. Has priority over any same-cycle pop.
- full=(level==DEPTH); empty=(level==0). Both are registered and consistent with level every cycle.
- Reset asserted mid-drain aborts immediately. Memory contents are not cleared, but are unreachable.
- FSM states: FILL (accept writes, outputs invalid), DRAIN (writes plus handshake pops). No other states; an illegal encoding recovers to FILL.

Test Plan:
- Reset then 3 write edges with data_in 0x11,0x22,0x33, then read edge, ready=1 -> data_out 0x11,0x22,0x33 on consecutive cycles, level 3->0, drain_done pulses once, state FILL.
- fifo_command held at 2'b10 for 5 cycles with data_in=0xAA -> exactly one entry, level=1.
- 256 write edges (data=index) then one more with data 0xDEAD -> full=1, overflow=1, level=256; drain yields 0..255 in order, wrap of pointers verified.
- Drain with data_out_ready toggling 1,0,0,1 -> data_out held stable during stall, no duplicates or skips.
- Write edge coincident with pop at level=1 -> level stays 1, empty stays 0, drain continues with new word.
- Read edge with FIFO empty -> drain_done pulses next cycle, data_out_valid never asserts; clear edge after overflow -> overflow=0, level=0; async reset mid-drain -> all outputs at reset values same cycle.
